// File: rtl/button_debounce_bank_pkg.sv
// Shared FSM state encoding, default timing constants and a counter-width helper
// for the push-button debounce bank.
package btn_debounce_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PWAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_RWAIT   = 2'd3;

  localparam int DEF_N_BTN           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Width able to hold 0 .. max_count-1; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/button_debounce_bank_if.sv
// Button bundle: raw inputs toward the debouncer, cleaned level and pulses back.
interface button_debounce_bank_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (output btn_raw, input btn_level, input btn_press, input btn_release);
  modport slave  (input btn_raw, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/button_debounce_bank_channel.sv
// Single button: 2-FF synchroniser, 4-state debounce FSM and registered press/release pulses.
// Optional auto-repeat of the press pulse while held is built only with BTN_AUTOREPEAT_EN.
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic             rpt_hit;

  // First repeat waits the long delay, later ones the shorter period.
  assign rpt_hit = rpt_armed_q ? (rpt_cnt_q == RPT_PERIOD_LAST)
                               : (rpt_cnt_q == RPT_DELAY_LAST);
`endif

  assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d = ST_PWAIT;
          cnt_d   = '0;
        end
      end
      ST_PWAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        level_d = 1'b1;
        if (!sync2_q) begin
          state_d = ST_RWAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else begin
          press_d     = rpt_hit;
          rpt_armed_d = rpt_armed_q | rpt_hit;
          rpt_cnt_d   = rpt_hit ? '0 : rpt_cnt_q + 1'b1;
        end
`endif
      end
      ST_RWAIT: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of N_BTN independent debounced push-button channels on the board clock.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_debounce_bank
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                  clk,
  input  logic                  reset,
  button_debounce_bank_if.slave btn
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (btn.btn_raw[g]),
      .level_o   (level_w[g]),
      .press_o   (press_w[g]),
      .release_o (release_w[g])
    );
  end

  assign btn.btn_level   = level_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_debounce_bank;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  button_debounce_bank_if #(.N_BTN(N)) bus ();

  button_debounce_bank #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge, then check all three output vectors just after it.
  task automatic step(input logic [3:0] el, input logic [3:0] ep, input logic [3:0] er,
                      input string tag);
    @(posedge clk);
    #1;
    total++;
    assert (bus.btn_level === el && bus.btn_press === ep && bus.btn_release === er)
    else begin
      bad++;
      $error("FAIL %s: level=%h press=%h release=%h, expected level=%h press=%h release=%h",
             tag, bus.btn_level, bus.btn_press, bus.btn_release, el, ep, er);
    end
  endtask

  // Raw already changed just after an edge: press registers at the 7th following edge (E6).
  task automatic expect_press(input logic [3:0] old_lvl, input logic [3:0] bits, input string tag);
    for (int i = 0; i < 6; i++) step(old_lvl, 4'h0, 4'h0, tag);
    step(old_lvl | bits, bits, 4'h0, tag);
    step(old_lvl | bits, 4'h0, 4'h0, tag);
  endtask

  task automatic expect_release(input logic [3:0] old_lvl, input logic [3:0] bits, input string tag);
    for (int i = 0; i < 6; i++) step(old_lvl, 4'h0, 4'h0, tag);
    step(old_lvl & ~bits, 4'h0, bits, tag);
    step(old_lvl & ~bits, 4'h0, 4'h0, tag);
  endtask

  initial begin
    logic [3:0] ep;
    logic [3:0] el;

    // Reset with every button held
    reset = 1'b1;
    bus.btn_raw = 4'hF;
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, "reset");
    reset = 1'b0;
    expect_press(4'h0, 4'hF, "post_reset_press");
    bus.btn_raw = 4'h0;
    expect_release(4'hF, 4'hF, "post_reset_release");

    // Clean press and release on channel 0
    bus.btn_raw = 4'h1;
    expect_press(4'h0, 4'h1, "ch0_press");
    bus.btn_raw = 4'h0;
    expect_release(4'h1, 4'h1, "ch0_release");

    // Short glitch on channel 1
    bus.btn_raw = 4'h2;
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, "glitch_hi");
    bus.btn_raw = 4'h0;
    for (int i = 0; i < 8; i++) step(4'h0, 4'h0, 4'h0, "glitch_lo");

    // Toggling faster than the debounce window
    for (int i = 0; i < 12; i++) begin
      bus.btn_raw = ((i / 3) % 2 == 0) ? 4'h2 : 4'h0;
      step(4'h0, 4'h0, 4'h0, "toggle");
    end
    bus.btn_raw = 4'h0;
    for (int i = 0; i < 6; i++) step(4'h0, 4'h0, 4'h0, "toggle_settle");

    // Simultaneous press on channels 2 and 3
    bus.btn_raw = 4'hC;
    expect_press(4'h0, 4'hC, "simul_press");
    bus.btn_raw = 4'h0;
    expect_release(4'hC, 4'hC, "simul_release");

    // Reset while channel 0 is pressed, button still held
    bus.btn_raw = 4'h1;
    expect_press(4'h0, 4'h1, "mid_press");
    reset = 1'b1;
    step(4'h0, 4'h0, 4'h0, "mid_reset");
    reset = 1'b0;
    expect_press(4'h0, 4'h1, "mid_repress");
    bus.btn_raw = 4'h0;
    expect_release(4'h1, 4'h1, "mid_release");

    // Long hold on channel 0: repeats at E16, E21, E26, ... only when enabled
    bus.btn_raw = 4'h1;
    for (int k = 1; k <= 38; k++) begin
      el = (k >= 7) ? 4'h1 : 4'h0;
      ep = ((k == 7) || (RPT_ON && k >= 17 && ((k - 17) % 5) == 0)) ? 4'h1 : 4'h0;
      step(el, ep, 4'h0, "hold");
    end
    bus.btn_raw = 4'h0;
    expect_release(4'h1, 4'h1, "hold_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
